// File: rtl/progmem_pkg.sv
// Shared widths, defaults and FSM state type for the program-memory loader/arbiter.
package progmem_pkg;

    localparam int PM_ADDR_W    = 14;
    localparam int PM_DATA_W    = 32;
    localparam int PM_BASE_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } pm_state_e;

endpackage

// File: rtl/progmem_loader_arb_if.sv
// Program-memory bus: the controller drives it as master, the memory macro is the slave.
interface progmem_loader_arb_if
    import progmem_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );

endinterface

// File: rtl/progmem_loader_arb_csum.sv
// Running 8-bit (mod 256) payload checksum; used only when LOADER_CHECKSUM_EN is defined.
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       acc_en,
    input  logic [7:0] byte_in,
    output logic [7:0] sum
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum + byte_in;
        end
    end

endmodule

// File: rtl/progmem_loader_arb.sv
// Arbitrates program memory between core fetches and a byte-stream boot loader.
// Optional trailing-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module progmem_loader_arb
    import progmem_pkg::*;
#(
    parameter int                ADDR_W    = PM_ADDR_W,
    parameter int                DATA_W    = PM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PM_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              core_hold,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_valid,

    progmem_loader_arb_if.master mem
);

    pm_state_e         state_q;
    pm_state_e         state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_rdata_q;

    logic rx_window;
    logic accept;
    logic wr_en;
    logic fetch_slot;
    logic start_load;
    logic last_byte;

    // Reset gates the byte window so no write can slip through on the reset cycle.
    assign rx_window  = (state_q == ST_LOAD || state_q == ST_CHECK) && !rst;
    assign accept     = rx_window && byte_valid;
    assign wr_en      = accept && (state_q == ST_LOAD);
    assign fetch_slot = (state_q == ST_IDLE || state_q == ST_DONE);
    assign start_load = (state_q == ST_IDLE) && load_start;
    assign last_byte  = (remaining_q == (ADDR_W+1)'(1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    logic       err_d;
    logic       err_q;

    loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_load),
        .acc_en  (wr_en),
        .byte_in (byte_data),
        .sum     (csum)
    );

    assign csum_ok  = (byte_data == csum);
    assign load_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        core_hold  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = (load_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                byte_ready = rx_window;
                load_busy  = 1'b1;
                core_hold  = 1'b1;
                if (accept && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                byte_ready = rx_window;
                load_busy  = 1'b1;
                core_hold  = 1'b1;
                if (accept) begin
                    if (csum_ok) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write pointer wraps modulo 2^ADDR_W through natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= BASE_ADDR;
            remaining_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_rdata_q <= '0;
        end else begin
            fetch_valid_q <= fetch_slot && fetch_req;
            if (fetch_slot && fetch_req) begin
                fetch_rdata_q <= mem.mem_dout;
            end
            if (start_load) begin
                wr_ptr_q    <= BASE_ADDR;
                remaining_q <= load_len;
            end else if (wr_en) begin
                wr_ptr_q    <= wr_ptr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign mem.mem_we   = wr_en;
    assign mem.mem_addr = fetch_slot ? fetch_addr : wr_ptr_q;
    assign mem.mem_din  = DATA_W'(byte_data);
    assign fetch_valid  = fetch_valid_q;
    assign fetch_rdata  = fetch_rdata_q;

endmodule
